// File: rtl/ws2812_pkg.sv
// Shared WS2812 constants, word type and receiver FSM encoding.
// The timing cycle counts assume a 27 MHz clock; the transmitter imports the same package.
package ws2812_pkg;

  localparam int unsigned CLK_FRE      = 27_000_000;
  localparam int unsigned WS2812_WIDTH = 24;
  localparam int unsigned T_BIT_THRESH = 16;
  localparam int unsigned T_HIGH_MAX   = 54;
  localparam int unsigned T_RESET      = 1350;
  localparam int unsigned IDX_W        = 9;

  localparam int unsigned LCNT_W = $clog2(T_RESET + 1);
  localparam int unsigned HCNT_W = $clog2(T_HIGH_MAX + 1);
  localparam int unsigned BCNT_W = $clog2(WS2812_WIDTH);

  typedef logic [WS2812_WIDTH-1:0] ws2812_word_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } ws2812_state_t;

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded-word output bundle of the WS2812 receiver.
interface ws2812_rx_if;
  import ws2812_pkg::*;

  ws2812_word_t     data_out;
  logic             data_valid;
  logic [IDX_W-1:0] led_index;
  logic             frame_done;
  logic             bit_err;

  modport master (
    output data_out,
    output data_valid,
    output led_index,
    output frame_done,
    output bit_err
  );

  modport slave (
    input data_out,
    input data_valid,
    input led_index,
    input frame_done,
    input bit_err
  );

endinterface

// File: rtl/ws2812_sync_edge.sv
// Two-flop synchroniser for the asynchronous WS2812 line plus registered edge pulses.
module ws2812_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic din_m;
  logic din_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_d <= din_s;
      rise  <= din_s & ~din_d;
      fall  <= ~din_s & din_d;
    end
  end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire decoder: classifies high pulses into bits, assembles
// LSB-first 24-bit words and flags frame boundaries on the reset-low period.
module ws2812_rx
  import ws2812_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  ws2812_rx_if.master     rx
);

  logic din_s;
  logic rise;
  logic fall;

  ws2812_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  ws2812_state_t             state_q,     state_d;
  logic [LCNT_W-1:0]         lcnt_q,      lcnt_d;
  logic [HCNT_W-1:0]         hcnt_q,      hcnt_d;
  logic [BCNT_W-1:0]         bit_cnt_q,   bit_cnt_d;
  logic [WS2812_WIDTH-2:0]   shreg_q,     shreg_d;
  logic [IDX_W-1:0]          word_cnt_q,  word_cnt_d;
  ws2812_word_t              data_out_q,  data_out_d;
  logic [IDX_W-1:0]          led_index_q, led_index_d;
  logic                      dv_q,        dv_d;
  logic                      fd_q,        fd_d;
  logic                      err_q,       err_d;
  logic                      bit_c;

  assign bit_c = (hcnt_q >= HCNT_W'(T_BIT_THRESH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lcnt_q      <= '0;
      hcnt_q      <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      word_cnt_q  <= '0;
      data_out_q  <= '0;
      led_index_q <= '0;
      dv_q        <= 1'b0;
      fd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      hcnt_q      <= hcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      word_cnt_q  <= word_cnt_d;
      data_out_q  <= data_out_d;
      led_index_q <= led_index_d;
      dv_q        <= dv_d;
      fd_q        <= fd_d;
      err_q       <= err_d;
    end
  end

  // Edges arrive one cycle after din_s, so hcnt/lcnt measure the exact pin pulse length.
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    hcnt_d      = hcnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    word_cnt_d  = word_cnt_q;
    data_out_d  = data_out_q;
    led_index_d = led_index_q;
    dv_d        = 1'b0;
    fd_d        = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (din_s) begin
          lcnt_d = '0;
        end else if (lcnt_q == LCNT_W'(T_RESET - 1)) begin
          lcnt_d  = '0;
          state_d = WAIT_HIGH;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end

      WAIT_HIGH: begin
        if (rise) begin
          hcnt_d  = HCNT_W'(1);
          state_d = MEAS_HIGH;
        end
      end

      MEAS_HIGH: begin
        if (fall) begin
          shreg_d = {bit_c, shreg_q[WS2812_WIDTH-2:1]};
          lcnt_d  = LCNT_W'(1);
          state_d = MEAS_LOW;
          if (bit_cnt_q == BCNT_W'(WS2812_WIDTH - 1)) begin
            data_out_d  = {bit_c, shreg_q};
            dv_d        = 1'b1;
            led_index_d = word_cnt_q;
            bit_cnt_d   = '0;
            if (word_cnt_q != '1) begin
              word_cnt_d = word_cnt_q + IDX_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end else if (hcnt_q == HCNT_W'(T_HIGH_MAX - 1)) begin
          // Stuck-high line: drop the partial word and re-qualify with a full reset-low.
          hcnt_d    = HCNT_W'(T_HIGH_MAX);
          err_d     = 1'b1;
          bit_cnt_d = '0;
          lcnt_d    = '0;
          state_d   = IDLE;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end

      MEAS_LOW: begin
        if (rise) begin
          hcnt_d  = HCNT_W'(1);
          state_d = MEAS_HIGH;
        end else if (lcnt_q == LCNT_W'(T_RESET - 1)) begin
          lcnt_d      = LCNT_W'(T_RESET);
          fd_d        = 1'b1;
          err_d       = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          word_cnt_d  = '0;
          led_index_d = '0;
          state_d     = WAIT_HIGH;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = dv_q;
  assign rx.led_index  = led_index_q;
  assign rx.frame_done = fd_q;
  assign rx.bit_err    = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: drivers predict events from pulse lengths at pin level,
// a negedge monitor pops and compares whenever the receiver pulses an output.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812_rx_if rx ();

  ws2812_rx dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .rx  (rx)
  );

  typedef struct {
    bit          dv;
    bit          fd;
    bit          err;
    logic [23:0] data;
    int          idx;
    int          at;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model: armed once a full reset-low has been seen, bits as a plain queue.
  bit  m_armed   = 1'b0;
  bit  m_bits[$];
  int  m_idx     = 0;
  int  m_low_run = 0;

  // The receiver sees the line three clocks late (two sync flops + edge register).
  localparam int LAG = 3;

  function automatic logic [23:0] bits_value();
    logic [23:0] w = 24'd0;
    for (int i = 0; i < m_bits.size(); i++)
      if (m_bits[i]) w = w + (24'd1 << i);
    return w;
  endfunction

  task automatic push_ev(input bit dv, input bit fd, input bit err,
                         input logic [23:0] data, input int idx, input int at);
    ev_t e;
    e.dv = dv; e.fd = fd; e.err = err; e.data = data; e.idx = idx; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic drive_high(input int h);
    int n;
    n = cyc;
    if (m_armed) begin
      if (h >= int'(T_HIGH_MAX)) begin
        push_ev(1'b0, 1'b0, 1'b1, 24'd0, 0, n + LAG + int'(T_HIGH_MAX));
        m_bits.delete();
        m_armed   = 1'b0;
        m_low_run = 0;
      end else begin
        m_bits.push_back(h >= int'(T_BIT_THRESH));
        if (m_bits.size() == int'(WS2812_WIDTH)) begin
          push_ev(1'b1, 1'b0, 1'b0, bits_value(), m_idx, n + h + LAG + 1);
          if (m_idx < (1 << IDX_W) - 1) m_idx++;
          m_bits.delete();
        end
      end
    end else begin
      m_low_run = 0;
    end
    din = 1'b1;
    repeat (h) begin @(posedge clk); #1; end
    din = 1'b0;
  endtask

  task automatic drive_low(input int l);
    int n;
    n = cyc;
    if (m_armed) begin
      if (l >= int'(T_RESET)) begin
        push_ev(1'b0, 1'b1, m_bits.size() != 0, 24'd0, 0, n + LAG + int'(T_RESET));
        m_bits.delete();
        m_idx = 0;
      end
    end else begin
      m_low_run += l;
      if (m_low_run >= int'(T_RESET)) m_armed = 1'b1;
    end
    din = 1'b0;
    repeat (l) begin @(posedge clk); #1; end
  endtask

  // mode 0: transmitter timing, 1: random timing, 2: 15/16-cycle threshold pulses
  task automatic send_bits(input logic [23:0] w, input int nb, input int mode, input int last_low);
    int h, l;
    for (int i = 0; i < nb; i++) begin
      case (mode)
        0:       begin h = w[i] ? 22 : 10; l = w[i] ? 12 : 23; end
        1:       begin h = w[i] ? int'($urandom_range(17, 50)) : int'($urandom_range(3, 15));
                       l = int'($urandom_range(4, 40)); end
        default: begin h = w[i] ? 16 : 15; l = 20; end
      endcase
      drive_high(h);
      drive_low((i == nb - 1) ? last_low : l);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_out"},   longint'(rx.data_out),   0);
    check({tag, "_data_valid"}, longint'(rx.data_valid), 0);
    check({tag, "_led_index"},  longint'(rx.led_index),  0);
    check({tag, "_frame_done"}, longint'(rx.frame_done), 0);
    check({tag, "_bit_err"},    longint'(rx.bit_err),    0);
  endtask

  ev_t mon_e;
  bit  mon_ok;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_event: dv=%0d fd=%0d err=%0d expected at cycle %0d, still pending at %0d",
               exp_q[0].dv, exp_q[0].fd, exp_q[0].err, exp_q[0].at, cyc);
      void'(exp_q.pop_front());
    end
    if (rx.data_valid || rx.frame_done || rx.bit_err) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: dv=%0d fd=%0d err=%0d data=%h idx=%0d at cycle %0d, expected none",
                 rx.data_valid, rx.frame_done, rx.bit_err, rx.data_out, rx.led_index, cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (mon_e.at == cyc) && (mon_e.dv == rx.data_valid) &&
                 (mon_e.fd == rx.frame_done) && (mon_e.err == rx.bit_err);
        if (mon_e.dv) mon_ok = mon_ok && (rx.data_out === mon_e.data) && (int'(rx.led_index) == mon_e.idx);
        if (mon_e.fd) mon_ok = mon_ok && (rx.led_index == '0);
        if (!mon_ok) begin
          n_bad++;
          $display("FAIL event: got dv=%0d fd=%0d err=%0d data=%h idx=%0d cyc=%0d, expected dv=%0d fd=%0d err=%0d data=%h idx=%0d cyc=%0d",
                   rx.data_valid, rx.frame_done, rx.bit_err, rx.data_out, rx.led_index, cyc,
                   mon_e.dv, mon_e.fd, mon_e.err, mon_e.data, mon_e.idx, mon_e.at);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // First reset-low qualifies the line without a frame_done.
    drive_low(1400);

    // Single-word frame with transmitter timing.
    send_bits(24'h000001, 24, 0, 1400);

    // Threshold boundary: zeros as 15-cycle pulses, ones as 16-cycle pulses.
    send_bits(24'h800000, 24, 2, 1400);
    send_bits(24'h5A3C96, 24, 2, 1400);

    // Three-word frame, then a fresh frame restarting at index 0.
    send_bits(24'hA5A5A5, 24, 0, 12);
    send_bits(24'h00FF00, 24, 0, 23);
    send_bits(24'hFFFFFF, 24, 0, 1400);
    send_bits(24'($urandom()), 24, 1, 1400);

    // Partial frame: 10 bits then reset-low gives bit_err with frame_done.
    send_bits(24'($urandom()), 10, 1, 1400);
    send_bits(24'($urandom()), 24, 1, 1400);

    // Stuck-high line, then a word that must be ignored until a reset-low.
    drive_high(60);
    drive_low(20);
    send_bits(24'($urandom()), 24, 1, 1400);
    send_bits(24'($urandom()), 24, 0, 1400);

    // Synchronous reset in the middle of bit 12.
    send_bits(24'($urandom() | 32'h1), 12, 0, 23);
    din = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    m_armed = 1'b0; m_bits.delete(); m_idx = 0; m_low_run = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs_zero("midword_rst");
    repeat (8) begin @(posedge clk); #1; end
    din = 1'b0;
    drive_low(1400);
    send_bits(24'($urandom()), 24, 1, 1400);

    // Random multi-word frames.
    for (int f = 0; f < 4; f++) begin
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++)
        send_bits(24'($urandom()), 24, 1, (k == nw - 1) ? 1400 : int'($urandom_range(4, 40)));
    end

    repeat (20) begin @(posedge clk); #1; end
    check("pending_events", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
